watchdog_kicker: RTL and testbench

- Bus-side master for the watchdog peripheral; drives its ABUS/DBUS write interface and monitors its RSTOUT.
- On START it programs the timeout reload and enable registers, then writes the two-byte kick key every KICK_PERIOD cycles.
- HALT suppresses kicks so the watchdog can be forced to fire; a fired watchdog is latched and reported.
- Sits between the system sequencer and watchdog_top.

---
 rtl/watchdog_kicker_if.sv | 25 ++
 rtl/watchdog_kicker.sv | 208 ++++++++++++++++++++
 tb/tb_watchdog_kicker.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/watchdog_kicker_if.sv
// -----------------------------------------------------------------------------
// watchdog_kicker_if
//
// Register-write bus between the watchdog kicker (master) and the watchdog
// peripheral (slave), plus the peripheral's reset output back to the master.
//
// Signals:
//   abus   [1:0]  register address: 0 = ctrl, 1 = reload, 2 = kick
//   dbus   [7:0]  write data
//   we            write strobe, one cycle per write
//   rstout        watchdog reset output, active-high
//
// Handshake: write-only bus with no back-pressure. The master drives abus and
// dbus for one setup cycle with we=0, then holds them for one strobe cycle with
// we=1; the slave captures on the strobe cycle and never stalls the master.
// -----------------------------------------------------------------------------
interface watchdog_kicker_if;
    logic [1:0] abus;
    logic [7:0] dbus;
    logic       we;
    logic       rstout;

    modport master (output abus, output dbus, output we, input rstout);
    modport slave  (input abus, input dbus, input we, output rstout);
endinterface

// File: rtl/watchdog_kicker.sv
// -----------------------------------------------------------------------------
// watchdog_kicker
//
// Bus master for the watchdog peripheral. On start it programs the reload and
// control registers, then writes the two-byte kick key every kick_period
// cycles. halt suppresses new kick sequences so the watchdog can be made to
// fire; a fire seen while armed is latched on fired and aborts all bus traffic.
//
// Optional feature (macro WATCHDOG_KICKER_KICKCNT_EN): adds kick_count[15:0],
// a wrapping count of KEY2 strobes, cleared by reset and by an accepted start.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   bus          watchdog_kicker_if.master (abus, dbus, we out; rstout in)
//   start        one-cycle pulse, accepted only in IDLE
//   timeout_cfg  reload value, sampled on an accepted start
//   kick_period  cycles between kick sequences, sampled on an accepted start
//   halt         level; while high no new kick sequence begins
//   armed        high from completion of the enable write until fire or reset
//   fired        sticky; set when rstout is seen high while armed
//   kick_count   (optional) KEY2 strobe count
//   dbg_state    current FSM state encoding
// -----------------------------------------------------------------------------
module watchdog_kicker #(
    parameter int unsigned PERIOD_W = 16,
    parameter logic [7:0]  KEY1     = 8'h5A,
    parameter logic [7:0]  KEY2     = 8'hA5,
    parameter logic [7:0]  EN_VAL   = 8'h01
) (
    input  logic                clk,
    input  logic                rst,
    watchdog_kicker_if.master   bus,
    input  logic                start,
    input  logic [7:0]          timeout_cfg,
    input  logic [PERIOD_W-1:0] kick_period,
    input  logic                halt,
    output logic                armed,
    output logic                fired,
`ifdef WATCHDOG_KICKER_KICKCNT_EN
    output logic [15:0]         kick_count,
`endif
    output logic [3:0]          dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_S = 4'd1,
        S_LOAD_W = 4'd2,
        S_EN_S   = 4'd3,
        S_EN_W   = 4'd4,
        S_WAIT   = 4'd5,
        S_K1_S   = 4'd6,
        S_K1_W   = 4'd7,
        S_K2_S   = 4'd8,
        S_K2_W   = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_RELOAD = 2'd1;
    localparam logic [1:0] A_KICK   = 2'd2;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [7:0]          timeout_q, timeout_d;
    logic [1:0]          abus_d;
    logic [7:0]          dbus_d;
    logic                we_d;
    logic                fire;
    logic                accept;

    assign fire      = bus.rstout & armed;
    assign accept    = (state_q == S_IDLE) & start;
    assign dbg_state = state_q;

    // Configuration is captured in the same cycle start is accepted, so the
    // first setup cycle already needs the incoming timeout value.
    always_comb begin
        timeout_d = timeout_q;
        period_d  = period_q;
        if (accept) begin
            timeout_d = timeout_cfg;
            // A zero period behaves as one: a single WAIT cycle between kicks.
            period_d  = (kick_period == '0) ? PERIOD_ONE : kick_period;
        end
    end

    // Next-state logic. A fire overrides every other transition, including a
    // counter expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        if (fire) begin
            state_d = S_FAULT;
        end else begin
            unique case (state_q)
                S_IDLE:   if (start) state_d = S_LOAD_S;
                S_LOAD_S: state_d = S_LOAD_W;
                S_LOAD_W: state_d = S_EN_S;
                S_EN_S:   state_d = S_EN_W;
                S_EN_W:   state_d = S_WAIT;
                S_WAIT:   if ((cnt_q == '0) && !halt) state_d = S_K1_S;
                S_K1_S:   state_d = S_K1_W;
                S_K1_W:   state_d = S_K2_S;
                S_K2_S:   state_d = S_K2_W;
                S_K2_W:   state_d = S_WAIT;
                S_FAULT:  if (!bus.rstout) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Bus values are decoded from the next state and registered, so the bus
    // outputs change cleanly on the clock edge that enters each state.
    always_comb begin
        abus_d = '0;
        dbus_d = '0;
        we_d   = 1'b0;
        unique case (state_d)
            S_LOAD_S, S_LOAD_W: begin
                abus_d = A_RELOAD;
                dbus_d = timeout_d;
            end
            S_EN_S, S_EN_W: begin
                abus_d = A_CTRL;
                dbus_d = EN_VAL;
            end
            S_K1_S, S_K1_W: begin
                abus_d = A_KICK;
                dbus_d = KEY1;
            end
            S_K2_S, S_K2_W: begin
                abus_d = A_KICK;
                dbus_d = KEY2;
            end
            default: ;
        endcase
        we_d = (state_d == S_LOAD_W) || (state_d == S_EN_W) ||
               (state_d == S_K1_W)   || (state_d == S_K2_W);
    end

    // Period counter: reloaded on every entry into WAIT, counts down to zero
    // and parks there while halt holds off the next kick.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S_WAIT) && (state_q != S_WAIT)) begin
            cnt_d = period_d - PERIOD_ONE;
        end else if ((state_q == S_WAIT) && (state_d == S_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - PERIOD_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            timeout_q <= '0;
            bus.abus  <= '0;
            bus.dbus  <= '0;
            bus.we    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
            bus.abus  <= abus_d;
            bus.dbus  <= dbus_d;
            bus.we    <= we_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
            fired <= 1'b0;
        end else begin
            if (fire) begin
                armed <= 1'b0;
            end else if (state_q == S_EN_W) begin
                armed <= 1'b1;
            end
            if (fire) begin
                fired <= 1'b1;
            end else if (accept) begin
                fired <= 1'b0;
            end
        end
    end

`ifdef WATCHDOG_KICKER_KICKCNT_EN
    // Counts KEY2 strobes; the strobe has already gone out even if a fire is
    // seen in the same cycle, so it is still counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kick_count <= '0;
        end else if (accept) begin
            kick_count <= '0;
        end else if (state_q == S_K2_W) begin
            kick_count <= kick_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_watchdog_kicker.sv
// -----------------------------------------------------------------------------
// tb_watchdog_kicker
//
// Bench for watchdog_kicker. The reference model describes the kicker as a
// schedule of bus writes: each write is an (edge, address, data) entry in an
// expected queue, derived from the timing rules (config writes two and four
// cycles after start, arming after the enable write, earliest kick decision
// one period after the previous write, halt delaying that decision, a fire
// discarding everything still pending). Every cycle the bus, armed, fired and
// (when present) kick_count are compared against that schedule.
// -----------------------------------------------------------------------------
module tb_watchdog_kicker;

    localparam int PW = 16;
    localparam int EW = 42;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          halt;
    logic [7:0]    timeout_cfg;
    logic [PW-1:0] kick_period;
    logic          armed;
    logic          fired;
    logic [3:0]    dbg_state;
`ifdef WATCHDOG_KICKER_KICKCNT_EN
    logic [15:0]   kick_count;
`endif

    watchdog_kicker_if bus ();

    watchdog_kicker #(.PERIOD_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .start       (start),
        .timeout_cfg (timeout_cfg),
        .kick_period (kick_period),
        .halt        (halt),
        .armed       (armed),
        .fired       (fired),
`ifdef WATCHDOG_KICKER_KICKCNT_EN
        .kick_count  (kick_count),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int edge_n       = 0;

    typedef enum {M_IDLE, M_RUN, M_FAULT} mode_t;
    mode_t       m_mode;
    bit          m_armed;
    bit          m_fired;
    bit          m_k2_prev;
    bit          m_k1_now;
    int          m_arm_at;
    int          m_dec_min;
    int          m_p;
    logic [15:0] m_kcnt;
    logic [EW-1:0] exp_q[$];

    bit spacing_on   = 1'b0;
    int last_k2_edge = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int cyc, input logic [1:0] a, input logic [7:0] d);
        logic [31:0] c;
        c = cyc;
        return {c, a, d};
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_armed   = 1'b0;
        m_fired   = 1'b0;
        m_k2_prev = 1'b0;
        m_k1_now  = 1'b0;
        m_kcnt    = '0;
        exp_q.delete();
    endtask

    // Advance the model across one rising edge with the inputs sampled there.
    task automatic model_edge(input bit st, input bit h, input bit ro);
        if (m_k2_prev) m_kcnt = m_kcnt + 16'd1;
        if (m_armed && ro) begin
            m_mode  = M_FAULT;
            m_armed = 1'b0;
            m_fired = 1'b1;
            exp_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (st) begin
                    m_mode    = M_RUN;
                    m_fired   = 1'b0;
                    m_kcnt    = '0;
                    m_p       = (kick_period == '0) ? 1 : int'(kick_period);
                    exp_q.push_back(mk(edge_n + 1, 2'd1, timeout_cfg));
                    exp_q.push_back(mk(edge_n + 3, 2'd0, 8'h01));
                    m_arm_at  = edge_n + 4;
                    m_dec_min = edge_n + 3 + m_p + 1;
                end
                M_RUN: begin
                    if (edge_n >= m_dec_min && !h) begin
                        exp_q.push_back(mk(edge_n + 1, 2'd2, 8'h5A));
                        exp_q.push_back(mk(edge_n + 3, 2'd2, 8'hA5));
                        m_dec_min = edge_n + 3 + m_p + 1;
                    end
                    m_armed = (edge_n >= m_arm_at);
                end
                M_FAULT: if (!ro) m_mode = M_IDLE;
                default: ;
            endcase
        end
    endtask

    // Compare all outputs after the current edge with the model.
    task automatic check_outputs();
        logic [EW-1:0] e;
        logic [1:0]    ea;
        logic [7:0]    ed;
        logic          ew;
        ea = '0; ed = '0; ew = 1'b0;
        m_k2_prev = 1'b0;
        m_k1_now  = 1'b0;
        e = '0;
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (int'(e[41:10]) == edge_n) begin
                ew = 1'b1; ea = e[9:8]; ed = e[7:0];
            end else if (int'(e[41:10]) == edge_n + 1) begin
                ea = e[9:8]; ed = e[7:0];
            end
        end
        check("we", 32'(bus.we), 32'(ew));
        check("abus", 32'(bus.abus), 32'(ea));
        check("dbus", 32'(bus.dbus), 32'(ed));
        check("armed", 32'(armed), 32'(m_armed));
        check("fired", 32'(fired), 32'(m_fired));
`ifdef WATCHDOG_KICKER_KICKCNT_EN
        check("kick_count", 32'(kick_count), 32'(m_kcnt));
`endif
        if (ew) begin
            void'(exp_q.pop_front());
            if (ea == 2'd2 && ed == 8'hA5) m_k2_prev = 1'b1;
            if (ea == 2'd2 && ed == 8'h5A) m_k1_now  = 1'b1;
        end
        if (spacing_on && bus.we && bus.abus == 2'd2) begin
            if (bus.dbus == 8'h5A && last_k2_edge >= 0)
                check("kick_spacing", 32'(edge_n - last_k2_edge), 32'(m_p + 2));
            if (bus.dbus == 8'hA5) last_k2_edge = edge_n;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: apply inputs, cross one rising edge, check.
    task automatic step(input bit st, input bit h, input bit ro);
        start      = st;
        halt       = h;
        bus.rstout = ro;
        @(posedge clk);
        edge_n++;
        model_edge(st, h, ro);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_k1();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (m_k1_now) ok = 1'b1;
        end
        check("k1_reached", 32'(ok), 32'd1);
    endtask

    task automatic fire_to_idle();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic start_cfg(input logic [7:0] cfg, input logic [PW-1:0] per);
        timeout_cfg = cfg;
        kick_period = per;
        step(1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ro_left;
        bit h;
        rst = 1'b0; start = 1'b0; halt = 1'b0; bus.rstout = 1'b0;
        timeout_cfg = '0; kick_period = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Configuration and periodic kicks.
        spacing_on = 1'b1; last_k2_edge = -1;
        start_cfg(8'h40, 16'd10);
        repeat (100) step(1'b0, 1'b0, 1'b0);
        spacing_on = 1'b0;

        // Start while busy is ignored.
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);

        // Long halt, then release.
        repeat (50) step(1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);

        // Halt raised between KEY1 and KEY2.
        run_until_k1();
        repeat (4) step(1'b0, 1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0, 1'b0);

        // Fire with a three-cycle rstout pulse, then reconfigure.
        repeat (3) step(1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        start_cfg(8'h22, 16'd3);
        repeat (40) step(1'b0, 1'b0, 1'b0);

        // Zero period: back-to-back kicks.
        fire_to_idle();
        spacing_on = 1'b1; last_k2_edge = -1;
        start_cfg(8'h7E, 16'd0);
        repeat (30) step(1'b0, 1'b0, 1'b0);
        spacing_on = 1'b0;

        // rstout before arming is ignored.
        fire_to_idle();
        start_cfg(8'h10, 16'd4);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("fired_pre_arm", 32'(fired), 32'd0);
        repeat (20) step(1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        ro_left = 0;
        h = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 250; i++) begin
                timeout_cfg = 8'($urandom_range(0, 255));
                kick_period = PW'($urandom_range(0, 6));
                if ($urandom_range(0, 9) == 0) h = ~h;
                if (ro_left == 0 && $urandom_range(0, 59) == 0) ro_left = $urandom_range(1, 3);
                step($urandom_range(0, 19) == 0, h, ro_left > 0);
                if (ro_left > 0) ro_left--;
            end
        end

        // Reset during a KEY1 strobe.
        fire_to_idle();
        start_cfg(8'h55, 16'd2);
        run_until_k1();
        #2 rst = 1'b0;
        #1;
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_abus", 32'(bus.abus), 32'd0);
        check("rst_dbus", 32'(bus.dbus), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_fired", 32'(fired), 32'd0);
`ifdef WATCHDOG_KICKER_KICKCNT_EN
        check("rst_kick_count", 32'(kick_count), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
